// File: rtl/key_event_debounce.sv
// Multi-channel key debouncer with press/release/long-press events.
// Each channel: 2-flop sync, debounce FSM, long/auto-repeat counter.
module key_event_debounce #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int KEY_CNT     = 8,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 0,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_CNT-1:0] keys,
    output logic [KEY_CNT-1:0] keys_stable,
    output logic [KEY_CNT-1:0] key_press,
    output logic [KEY_CNT-1:0] key_release,
    output logic [KEY_CNT-1:0] key_long
);

    localparam int DB_CYC   = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYC = CLK_FREQ / 1000 * LONG_MS;
    localparam int REP_CYC  = CLK_FREQ / 1000 * REPEAT_MS;
    localparam int LONG_MAX = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
    localparam int DBW      = $clog2(DB_CYC + 1);
    localparam int LW       = $clog2(LONG_MAX + 1);
    localparam logic REL    = (ACTIVE_LOW != 0);
    localparam logic REP_EN = (REP_CYC > 0);

    typedef enum logic {
        IDLE,
        SAMPLING
    } state_t;

    logic [KEY_CNT-1:0] sync1;
    logic [KEY_CNT-1:0] sync2;

    // Two-flop synchronizer, reset to the released level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= {KEY_CNT{REL}};
            sync2 <= {KEY_CNT{REL}};
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < KEY_CNT; g++) begin : g_ch
        state_t         state;
        state_t         state_nx;
        logic [DBW-1:0] db_cnt;
        logic [DBW-1:0] db_cnt_nx;
        logic           commit;
        logic           s;
        logic           stable;
        logic           press;
        logic           release_p;
        logic           long_p;
        logic           rep_ph;
        logic [LW-1:0]  long_cnt;

        assign s              = sync2[g];
        assign keys_stable[g] = stable;
        assign key_press[g]   = press;
        assign key_release[g] = release_p;
        assign key_long[g]    = long_p;

        // Debounce state and counter registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= IDLE;
                db_cnt <= '0;
            end else begin
                state  <= state_nx;
                db_cnt <= db_cnt_nx;
            end
        end

        // Next state: a level must differ for DB_CYC counts to commit.
        always_comb begin
            state_nx  = state;
            db_cnt_nx = '0;
            commit    = 1'b0;
            unique case (state)
                IDLE: begin
                    if (s != stable) begin
                        state_nx = SAMPLING;
                    end
                end
                SAMPLING: begin
                    if (s == stable) begin
                        state_nx = IDLE;
                    end else if (db_cnt == DBW'(DB_CYC - 1)) begin
                        commit   = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        db_cnt_nx = db_cnt + 1'b1;
                    end
                end
            endcase
        end

        // Stable level, edge pulses, and long-press / repeat timing.
        // rep_ph selects the repeat period once the first long pulse fired.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stable    <= REL;
                press     <= 1'b0;
                release_p <= 1'b0;
                long_p    <= 1'b0;
                rep_ph    <= 1'b0;
                long_cnt  <= '0;
            end else begin
                press     <= 1'b0;
                release_p <= 1'b0;
                long_p    <= 1'b0;
                if (commit) begin
                    stable    <= s;
                    press     <= (s != REL);
                    release_p <= (s == REL);
                    long_cnt  <= '0;
                    rep_ph    <= 1'b0;
                    if (s != REL && LONG_CYC == 1) begin
                        long_p <= 1'b1;
                        rep_ph <= REP_EN;
                    end
                end else if (stable == REL) begin
                    long_cnt <= '0;
                    rep_ph   <= 1'b0;
                end else if (rep_ph) begin
                    if (long_cnt == LW'(REP_CYC - 1)) begin
                        long_p   <= 1'b1;
                        long_cnt <= '0;
                    end else begin
                        long_cnt <= long_cnt + 1'b1;
                    end
                end else if (long_cnt != LW'(LONG_CYC - 1)) begin
                    long_cnt <= long_cnt + 1'b1;
                    if (long_cnt == LW'(LONG_CYC - 2)) begin
                        long_p <= 1'b1;
                        if (REP_EN) begin
                            rep_ph   <= 1'b1;
                            long_cnt <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_key_event_debounce.sv
// Bench for key_event_debounce: two instances (repeat off / on),
// run-length reference model feeding a scoreboard queue.
module tb_key_event_debounce;

    localparam int DB = 10;
    localparam int LC = 50;
    localparam int RC = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] keys = 4'hf;

    logic [3:0] st0, pr0, rl0, lg0;
    logic [3:0] st1, pr1, rl1, lg1;

    key_event_debounce #(
        .CLK_FREQ(10_000), .KEY_CNT(4), .DEBOUNCE_MS(1),
        .LONG_MS(5), .REPEAT_MS(0), .ACTIVE_LOW(1)
    ) dut0 (
        .clk(clk), .rst(rst), .keys(keys),
        .keys_stable(st0), .key_press(pr0),
        .key_release(rl0), .key_long(lg0)
    );

    key_event_debounce #(
        .CLK_FREQ(10_000), .KEY_CNT(4), .DEBOUNCE_MS(1),
        .LONG_MS(5), .REPEAT_MS(1), .ACTIVE_LOW(1)
    ) dut1 (
        .clk(clk), .rst(rst), .keys(keys),
        .keys_stable(st1), .key_press(pr1),
        .key_release(rl1), .key_long(lg1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] l0;
        logic [3:0] l1;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // Reference model: the level seen two edges late must disagree with
    // the stable level on DB+1 consecutive edges to commit; long pulses
    // are timed from the press edge.
    logic [3:0] d1 = 4'hf;
    logic [3:0] d2 = 4'hf;
    logic [3:0] stb = 4'hf;
    int run[4];
    int held[4];

    always @(posedge clk) begin
        exp_t e;
        logic [3:0] s;
        e = '0;
        if (rst) begin
            d1 = 4'hf;
            d2 = 4'hf;
            stb = 4'hf;
            for (int i = 0; i < 4; i++) begin
                run[i] = 0;
                held[i] = 0;
            end
        end else begin
            s = d2;
            d2 = d1;
            d1 = keys;
            for (int i = 0; i < 4; i++) begin
                if (s[i] != stb[i]) run[i]++;
                else run[i] = 0;
                if (run[i] == DB + 1) begin
                    stb[i] = s[i];
                    run[i] = 0;
                    held[i] = 0;
                    if (!s[i]) e.pr[i] = 1'b1;
                    else e.rl[i] = 1'b1;
                end else if (!stb[i]) begin
                    held[i]++;
                    if (held[i] == LC - 1) begin
                        e.l0[i] = 1'b1;
                        e.l1[i] = 1'b1;
                    end else if (held[i] > LC - 1 &&
                                 (held[i] - (LC - 1)) % RC == 0) begin
                        e.l1[i] = 1'b1;
                    end
                end
            end
        end
        e.st = stb;
        q.push_back(e);
    end

    task automatic check(input string n, input logic [15:0] act,
                         input logic [15:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s t=%0t got st/pr/rl/lg=%h required %h",
                     n, $time, act, exp_v);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("dut0", {st0, pr0, rl0, lg0}, {e.st, e.pr, e.rl, e.l0});
            check("dut1", {st1, pr1, rl1, lg1}, {e.st, e.pr, e.rl, e.l1});
        end
    end

    task automatic cyc(input logic [3:0] k, input int n);
        keys = k;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] k;
        cyc(4'hf, 4);
        rst = 1'b0;
        cyc(4'hf, 5);
        // single press on key 0
        cyc(4'b1110, 30);
        cyc(4'hf, 30);
        // key 1 chatter for 100 cycles
        for (int i = 0; i < 20; i++) begin
            cyc((i % 2 == 0) ? 4'b1101 : 4'b1111, 5);
        end
        cyc(4'hf, 30);
        // key 2 held 80 cycles
        cyc(4'b1011, 80);
        cyc(4'hf, 30);
        // key 3 held 100 cycles
        cyc(4'b0111, 100);
        cyc(4'hf, 30);
        // reset in the middle of sampling, key stays held
        cyc(4'b1110, 9);
        rst = 1'b1;
        cyc(4'b1110, 3);
        rst = 1'b0;
        cyc(4'b1110, 30);
        cyc(4'hf, 30);
        // two keys together, key 3 bounces once
        cyc(4'b0110, 4);
        cyc(4'b1110, 1);
        cyc(4'b0110, 30);
        cyc(4'hf, 30);
        // reset while a long count is in progress
        cyc(4'b0000, 40);
        rst = 1'b1;
        cyc(4'b0000, 2);
        rst = 1'b0;
        cyc(4'b0000, 70);
        cyc(4'hf, 30);
        // randomized segments
        for (int i = 0; i < 150; i++) begin
            k = 4'($urandom);
            if ($urandom_range(0, 30) == 0) begin
                rst = 1'b1;
                cyc(k, 2);
                rst = 1'b0;
            end
            cyc(k, $urandom_range(1, 70));
        end
        cyc(4'hf, 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
